// File: rtl/jelly_mipi_rx_deskew_pkg.sv
// Shared definitions for the MIPI RX lane deskew block: FSM state encoding
// and a constant clog2 helper for deriving tap/offset widths.
package jelly_mipi_rx_deskew_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  // Ceiling log2, usable in parameter expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/jelly_mipi_rx_lane_delay.sv
// Single-lane variable-tap delay line for {active, valid, sync, data}.
// Stage k holds the input delayed k cycles; the tap d (1..DEPTH) picks the
// stage that feeds the output register. Control bits are cleared by reset,
// data bits are left unreset.
module jelly_mipi_rx_lane_delay #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAP_WIDTH  = 3
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic [DATA_WIDTH+2:0] i_data,
  input  logic [TAP_WIDTH-1:0]  i_d,
  output logic [DATA_WIDTH+2:0] o_data
);

  localparam int unsigned W = DATA_WIDTH + 3;

  logic [DEPTH:1][W-1:0] r_stage;
  logic [W-1:0]          w_sel;
  logic [W-1:0]          r_out;

  // Shift chain; reset only invalidates the three control bits of each stage
  always_ff @(posedge clk) begin
    r_stage[1] <= i_data;
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      r_stage[k] <= r_stage[k-1];
    end
    if (reset) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_stage[k][W-1 -: 3] <= 3'b000;
      end
    end
  end

  // Tap select; out-of-range taps fall back to the deepest stage
  always_comb begin
    w_sel = r_stage[DEPTH];
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (i_d == TAP_WIDTH'(k)) begin
        w_sel = r_stage[k];
      end
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    r_out <= w_sel;
    if (reset) begin
      r_out[W-1 -: 3] <= 3'b000;
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/jelly_mipi_rx_lane_deskew.sv
// Multi-lane MIPI D-PHY HS receive deskew. Measures each lane's sync arrival
// offset inside a MAX_SKEW window after the earliest sync, then delays early
// lanes so all lanes present sync and payload in the same cycle.
// Optional macro JELLY_MIPI_RX_DESKEW_STICKY_ERROR_EN: out_error latches on
// the first skew error and holds until reset.
module jelly_mipi_rx_lane_deskew
  import jelly_mipi_rx_deskew_pkg::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_SKEW   = 3,
  parameter int unsigned SKEW_WIDTH = clog2(MAX_SKEW + 2)
) (
  input  logic                        reset,
  input  logic                        clk,
  input  logic [LANES*DATA_WIDTH-1:0] in_rxdatahs,
  input  logic [LANES-1:0]            in_rxvalidhs,
  input  logic [LANES-1:0]            in_rxactivehs,
  input  logic [LANES-1:0]            in_rxsynchs,
  output logic [LANES*DATA_WIDTH-1:0] out_rxdatahs,
  output logic [LANES-1:0]            out_rxvalidhs,
  output logic [LANES-1:0]            out_rxactivehs,
  output logic [LANES-1:0]            out_rxsynchs,
  output logic                        out_aligned,
  output logic                        out_error
);

  localparam int unsigned DEPTH = MAX_SKEW + 1;
  localparam int unsigned LW    = DATA_WIDTH + 3;
  localparam logic [SKEW_WIDTH-1:0] TAP_DEFAULT = SKEW_WIDTH'(DEPTH);
  localparam logic [SKEW_WIDTH-1:0] CNT_LAST    = SKEW_WIDTH'(MAX_SKEW);

  logic [LANES*DATA_WIDTH-1:0] r_st0_data;
  logic [LANES-1:0]            r_st0_valid;
  logic [LANES-1:0]            r_st0_active;
  logic [LANES-1:0]            r_st0_sync;

  logic [1:0]                        r_state, w_state_next;
  logic [SKEW_WIDTH-1:0]             r_cnt, w_cnt_next;
  logic [LANES-1:0]                  r_seen, w_seen_next;
  logic [LANES-1:0][SKEW_WIDTH-1:0]  r_arr, w_arr_next;
  logic [LANES-1:0][SKEW_WIDTH-1:0]  r_tap, w_tap_next;
  logic                              r_aligned, w_aligned_next;
  logic                              r_error, w_error_next;

  // Input stage data (unreset)
  always_ff @(posedge clk) begin
    r_st0_data <= in_rxdatahs;
  end

  // Input stage control bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st0_valid  <= '0;
      r_st0_active <= '0;
      r_st0_sync   <= '0;
    end else begin
      r_st0_valid  <= in_rxvalidhs;
      r_st0_active <= in_rxactivehs;
      r_st0_sync   <= in_rxsynchs;
    end
  end

  // FSM and measurement state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_seen    <= '0;
      r_arr     <= '0;
      r_tap     <= {LANES{TAP_DEFAULT}};
      r_aligned <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_seen    <= w_seen_next;
      r_arr     <= w_arr_next;
      r_tap     <= w_tap_next;
      r_aligned <= w_aligned_next;
      r_error   <= w_error_next;
    end
  end

  // Next-state: sync arrival measurement, tap computation and burst tracking
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_seen_next  = r_seen;
    w_arr_next   = r_arr;
    w_tap_next   = r_tap;

    case (r_state)
      ST_IDLE: begin
        if (|r_st0_sync) begin
          // This cycle counts as offset 0 for every lane syncing now
          w_state_next = ST_MEASURE;
          w_cnt_next   = SKEW_WIDTH'(1);
          w_seen_next  = r_st0_sync;
          w_arr_next   = '0;
        end
      end

      ST_MEASURE: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (r_st0_sync[i] && !r_seen[i]) begin
            w_seen_next[i] = 1'b1;
            w_arr_next[i]  = r_cnt;
          end
        end
        if (r_cnt == CNT_LAST) begin
          if (&w_seen_next) begin
            w_state_next = ST_LOCKED;
            for (int unsigned i = 0; i < LANES; i++) begin
              w_tap_next[i] = TAP_DEFAULT - w_arr_next[i];
            end
          end else begin
            w_state_next = ST_ERROR;
            w_tap_next   = {LANES{TAP_DEFAULT}};
          end
        end else begin
          w_cnt_next = r_cnt + SKEW_WIDTH'(1);
        end
      end

      ST_LOCKED, ST_ERROR: begin
        // Taps are held across the return to IDLE until the next lock
        if (~|r_st0_active) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_aligned_next = (w_state_next == ST_LOCKED);
`ifdef JELLY_MIPI_RX_DESKEW_STICKY_ERROR_EN
    w_error_next   = r_error | (w_state_next == ST_ERROR);
`else
    w_error_next   = (w_state_next == ST_ERROR);
`endif
  end

  assign out_aligned = r_aligned;
  assign out_error   = r_error;

  // Per-lane delay lines sharing one tap for data, valid, active and sync
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LW-1:0] w_in;
    logic [LW-1:0] w_out;

    assign w_in = {r_st0_active[g], r_st0_valid[g], r_st0_sync[g],
                   r_st0_data[g*DATA_WIDTH +: DATA_WIDTH]};

    jelly_mipi_rx_lane_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .TAP_WIDTH  (SKEW_WIDTH)
    ) u_delay (
      .reset  (reset),
      .clk    (clk),
      .i_data (w_in),
      .i_d    (r_tap[g]),
      .o_data (w_out)
    );

    assign out_rxactivehs[g]                        = w_out[LW-1];
    assign out_rxvalidhs[g]                         = w_out[LW-2];
    assign out_rxsynchs[g]                          = w_out[LW-3];
    assign out_rxdatahs[g*DATA_WIDTH +: DATA_WIDTH] = w_out[DATA_WIDTH-1:0];
  end

endmodule

// File: doc/jelly_mipi_rx_lane_deskew.md
Name: jelly_mipi_rx_lane_deskew

Overview:
- Multi-lane MIPI D-PHY HS receive deskew for PPI-side byte streams, parametrised in lane count, data width and maximum tolerated skew.
- Measures per-lane sync arrival offset within a bounded window, then delays each early lane through a variable-tap delay line so all lanes present sync and payload in the same cycle.
- Sits between the PHY PPI outputs and the lane merger / CSI-2 packet decoder.
- Reports lock status and a skew-overflow error.

Parameters:
- LANES, 2, number of HS data lanes (1..8)
- DATA_WIDTH, 8, bits per lane per cycle (8 or 16)
- MAX_SKEW, 3, maximum tolerated inter-lane sync offset in clk cycles (1..15)
- SKEW_WIDTH, $clog2(MAX_SKEW+2), width of per-lane offset/tap values (derived, do not override)

Ports:
- reset  in  1  synchronous, active-high reset
- clk  in  1  byte clock
- in_rxdatahs  in  LANES*DATA_WIDTH  per-lane HS data; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_rxvalidhs  in  LANES  per-lane data valid
- in_rxactivehs  in  LANES  per-lane HS active
- in_rxsynchs  in  LANES  per-lane sync-byte strobe
- out_rxdatahs  out  LANES*DATA_WIDTH  deskewed data
- out_rxvalidhs  out  LANES  deskewed valid
- out_rxactivehs  out  LANES  deskewed active
- out_rxsynchs  out  LANES  deskewed sync
- out_aligned  out  1  high while the FSM is in LOCKED
- out_error  out  1  skew-overflow / missing-sync indication

Behaviour:
- Reset: all pipeline registers, valid/active/sync bits, out_aligned and out_error go to 0. Data registers go to x. FSM enters IDLE. All taps d_i = MAX_SKEW+1.
- Datapath per lane:
  - input register st0;
  - delay line of MAX_SKEW+1 stages fed from st0 (stage k = st0 delayed k cycles);
  - mux selects stage d_i, d_i in 1..MAX_SKEW+1;
  - registered output.
  - Latency from in to out = d_i+2 cycles. All four signals of a lane share the same tap.
- Unlocked/default: every d_i = MAX_SKEW+1, giving a uniform MAX_SKEW+3 cycle latency.
- FSM states: IDLE, MEASURE, LOCKED, ERROR. The FSM observes the st0 signals.
- IDLE -> MEASURE: on the first cycle with any st0 sync bit set. In that cycle cnt = 0, and arr_i = 0 / seen_i = 1 for every lane whose sync bit is set.
- MEASURE:
  - cnt increments each cycle.
  - A lane whose sync first appears at count c records arr_i = c. Later syncs on an already-seen lane are ignored.
  - When cnt == MAX_SKEW and all seen_i are set (including those set this cycle): d_i <= MAX_SKEW+1-arr_i, go to LOCKED.
  - Otherwise go to ERROR, with taps restored to default.
- Timing: with T0 = earliest lane's input sync cycle, taps are valid from T0+MAX_SKEW+2. out_aligned rises at T0+MAX_SKEW+2. All lanes' out_rxsynchs assert together at T0+MAX_SKEW+3.
- LOCKED:
  - Taps are held.
  - New sync pulses are ignored (no re-measure within a burst).
  - Exit to IDLE when all st0 active bits are 0. Taps are retained until the next measurement completes.
- ERROR:
  - out_error asserted (see optional feature).
  - Exit to IDLE when all st0 active bits are 0.
- Simultaneous events:
  - A sync in the same cycle as all-active-low while in LOCKED/ERROR: go to IDLE. That sync is not measured.
  - A sync in the same cycle as the cnt==MAX_SKEW decision counts as within the window.
- LANES==1: MEASURE always succeeds with d_0 = MAX_SKEW+1.
- Reset mid-MEASURE or mid-LOCKED: immediate return to the reset state. Delay-line contents are invalidated (valid/sync cleared).

Optional Feature:
- Macro: JELLY_MIPI_RX_DESKEW_STICKY_ERROR_EN.
- Defined: out_error is set on entry to ERROR and held until reset, surviving later successful locks.
- Undefined: out_error = (state == ERROR), clearing on return to IDLE.

Decomposition:
- Shared package/header jelly_mipi_rx_deskew_pkg holds:
  - state encoding constants (IDLE=0, MEASURE=1, LOCKED=2, ERROR=3);
  - a clog2 helper function.
- Natural sub-module: jelly_mipi_rx_lane_delay.
  - Function: single-lane DATA_WIDTH+3 bit variable-tap delay line plus output register, tap input d, parameter DEPTH = MAX_SKEW+1.
  - Instantiated LANES times from a generate loop.

Test Plan (LANES=2, DATA_WIDTH=8, MAX_SKEW=3):
- Zero skew: both lanes sync 0xB8 at T0 -> d=(4,4); out_aligned=1 at T0+5; both out_rxsynchs and out_rxdatahs=0xB8 at T0+6.
- Lane1 late by 2 (sync at T0+2) -> d0=4, d1=2; both lanes output 0xB8 with sync at T0+6; subsequent payload bytes aligned byte-for-byte.
- Lane1 sync at T0+4 (skew 4 > MAX_SKEW) -> ERROR at T0+5; out_error=1; out_aligned=0; taps (4,4).
- Burst end then new burst with lane0 late by 3 -> IDLE, then re-measure gives d0=1, d1=4; aligned sync at T0'+6. Without the macro, out_error clears on IDLE; with it, out_error stays 1.
- Spurious second sync on lane0 during LOCKED -> taps unchanged, out_aligned stays 1; reset asserted during MEASURE -> all outputs 0 next cycle, FSM in IDLE.
